controller: RTL and testbench
=============================

Name: controller

Overview:
- Multicycle MIPS control unit. A Moore main FSM plus a combinational ALU decoder.
- Consumes instruction opcode/funct and the ALU zero flag from the datapath.
- Drives all datapath mux selects, write enables and the ALU operation code.
- Supports R-type (add, sub, and, or, slt), lw, sw, beq, addi and j.

Parameters:
- none (all encodings are package constants)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- op  input  6  instruction opcode [31:26]
- funct  input  6  instruction funct [5:0]
- zero  input  1  ALU result-is-zero flag
- pcen  output  1  PC register enable
- memwrite  output  1  memory write enable
- irwrite  output  1  instruction register write enable
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  output  1  writeback select: 0 = ALUOut, 1 = Data register
- regdst  output  1  destination register select: 0 = rt, 1 = rd
- alusrcb  output  2  ALU B select: 00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  output  4  ALU operation code

Behaviour:
- State register: 4 bits. On a clk edge with reset==0 it loads FETCH; otherwise it loads the next state.
- Outputs are a function of the current state, op, funct and zero only. Any signal not listed for a state is 0.
- While reset==0, pcen, memwrite, irwrite and regwrite are forced to 0. Other outputs keep their FETCH values.
- Internal aluop (2 bits) and branch (1 bit) are generated per state.
- pcen = pcwrite | (branch & zero).
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- State sequence and per-state outputs:
  - FETCH(0) -> DECODE. irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE(1) -> by op: LW/SW -> MEMADR, RTYPE -> RTYPEEX, BEQ -> BEQEX, ADDI -> ADDIEX, J -> JEX, any other op -> FETCH. Outputs: alusrcb=11, aluop=00.
  - MEMADR(2) -> MEMRD if op==LW, else MEMWR. alusrca=1, alusrcb=10.
  - MEMRD(3) -> MEMWB. iord=1.
  - MEMWB(4) -> FETCH. memtoreg=1, regwrite=1.
  - MEMWR(5) -> FETCH. iord=1, memwrite=1.
  - RTYPEEX(6) -> RTYPEWB. alusrca=1, aluop=10.
  - RTYPEWB(7) -> FETCH. regdst=1, regwrite=1.
  - BEQEX(8) -> FETCH. alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX(9) -> ADDIWB. alusrca=1, alusrcb=10.
  - ADDIWB(10) -> FETCH. regwrite=1.
  - JEX(11) -> FETCH. pcsrc=10, pcwrite=1.
  - Unused encodings 12-15 -> FETCH, all outputs 0.
- Cycle counts per instruction: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
- ALU decoder (combinational):
  - aluop 00 -> 0010 (add).
  - aluop 01 -> 0110 (sub).
  - aluop 10 decodes funct: 100000 -> 0010 add, 100010 -> 0110 sub, 100100 -> 0000 and, 100101 -> 0001 or, 101010 -> 0111 slt. Any other funct -> 0010.
  - aluop 11 -> 0010.
- zero affects only pcen, and only in BEQEX (or BNEEX when enabled).
- Reset asserted mid-instruction: the FSM returns to FETCH at the next edge and the instruction is abandoned.

Optional Feature:
- Macro: CTRL_BNE_EN.
- Defined:
  - Opcode BNE 000101 in DECODE -> BNEEX(12) -> FETCH.
  - BNEEX outputs: alusrca=1, aluop=01, pcsrc=01.
  - pcen = pcwrite | (branch & zero) | (branchne & ~zero).
- Undefined: opcode 000101 is treated as unknown (DECODE -> FETCH), and state 12 is unused.

Decomposition:
- Package controller_pkg holds:
  - opcode and funct constants;
  - the state enum (4-bit) with the encodings above;
  - aluop codes;
  - alucontrol codes.
- One sub-module, alu_decoder (aluop, funct -> alucontrol). The FSM and output logic stay in controller.

Test Plan:
- Hold reset=0 for 1 edge, then reset=1, op=000000, funct=100000 -> states FETCH, DECODE, RTYPEEX, RTYPEWB. In RTYPEEX alucontrol=0010, alusrca=1. In RTYPEWB regwrite=1, regdst=1. FETCH recurs after 4 cycles.
- R-type with funct 100010/100100/100101/101010 -> alucontrol 0110/0000/0001/0111 in RTYPEEX; funct 111111 -> 0010.
- op=100011 -> 5-cycle sequence; MEMRD iord=1; MEMWB memtoreg=1, regwrite=1. op=101011 -> 4 cycles, MEMWR memwrite=1, iord=1, regwrite=0.
- op=000100 with zero=0 -> BEQEX pcen=0, pcsrc=01, alucontrol=0110. Same with zero=1 -> pcen=1. Both return to FETCH after 3 cycles.
- op=001000 -> ADDIEX alusrcb=10, then ADDIWB regwrite=1, regdst=0. op=000010 -> JEX pcen=1, pcsrc=10 regardless of zero. Undefined op=111111 -> DECODE then FETCH.
- Assert reset=0 during MEMRD -> next state FETCH; write enables stay 0 while reset is low. Repeat all ops with zero=1 and confirm only beq (and bne when CTRL_BNE_EN is defined) changes.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, funct
// codes, FSM states, aluop and alucontrol values.
package controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSV   = 2'b11
  } aluop_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/controller_if.sv
// Controller <-> datapath bundle. master = datapath side, slave = controller.
interface controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [3:0] alucontrol;

  modport master (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
           regdst, alusrcb, pcsrc, alucontrol
  );

  modport slave (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
           regdst, alusrcb, pcsrc, alucontrol
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: aluop + funct -> alucontrol.
module alu_decoder
  import controller_pkg::*;
(
  input  aluop_e     aluop,
  input  logic [5:0] funct,
  output logic [3:0] alucontrol
);

  // aluop picks add/sub directly; only the R-type class looks at funct
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB:   alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default:     alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Multicycle MIPS control unit: Moore main FSM + ALU decoder.
// Optional macro CTRL_BNE_EN adds the bne instruction (state BNEEX).
module controller
  import controller_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  controller_if.slave bus
);

  state_e state_q, state_d;
  state_e out_s;
  aluop_e aluop;
  logic   pcwrite, branch, branchne;
  logic   irwrite_c, memwrite_c, regwrite_c;

  // state register, synchronous active-low reset back to FETCH
  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef CTRL_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // While reset is low the outputs look like FETCH (write enables masked below)
  assign out_s = reset ? state_q : S_FETCH;

  // per-state Moore outputs, everything defaults to 0
  always_comb begin
    irwrite_c   = 1'b0;
    memwrite_c  = 1'b0;
    regwrite_c  = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    branchne    = 1'b0;
    aluop       = ALUOP_ADD;
    bus.alusrca  = 1'b0;
    bus.iord     = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    case (out_s)
      S_FETCH: begin
        irwrite_c   = 1'b1;
        pcwrite     = 1'b1;
        bus.alusrcb = 2'b01;
      end
      S_DECODE:  bus.alusrcb = 2'b11;
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD:   bus.iord = 1'b1;
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite_c   = 1'b1;
      end
      S_MEMWR: begin
        bus.iord   = 1'b1;
        memwrite_c = 1'b1;
      end
      S_RTYPEEX: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        bus.regdst = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BEQEX: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_SUB;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_ADDIWB:  regwrite_c = 1'b1;
      S_JEX: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
`ifdef CTRL_BNE_EN
      S_BNEEX: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_SUB;
        bus.pcsrc   = 2'b01;
        branchne    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // enables are gated by reset so nothing commits while the core is held
  assign bus.pcen     = reset & (pcwrite | (branch & bus.zero) | (branchne & ~bus.zero));
  assign bus.irwrite  = reset & irwrite_c;
  assign bus.memwrite = reset & memwrite_c;
  assign bus.regwrite = reset & regwrite_c;

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: walks each instruction class through
// the FSM and compares the full output signature in every state.
module tb_controller;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  controller_if bus ();

  controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {pcen,memwrite,irwrite,regwrite, alusrca,iord,memtoreg,regdst, alusrcb, pcsrc, alucontrol}
  logic [15:0] sig;
  assign sig = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite,
                bus.alusrca, bus.iord, bus.memtoreg, bus.regdst,
                bus.alusrcb, bus.pcsrc, bus.alucontrol};

  localparam logic [15:0] E_RST     = 16'b0000_0000_01_00_0010;
  localparam logic [15:0] E_FETCH   = 16'b1010_0000_01_00_0010;
  localparam logic [15:0] E_DECODE  = 16'b0000_0000_11_00_0010;
  localparam logic [15:0] E_MEMADR  = 16'b0000_1000_10_00_0010;
  localparam logic [15:0] E_MEMRD   = 16'b0000_0100_00_00_0010;
  localparam logic [15:0] E_MEMWB   = 16'b0001_0010_00_00_0010;
  localparam logic [15:0] E_MEMWR   = 16'b0100_0100_00_00_0010;
  localparam logic [15:0] E_RWB     = 16'b0001_0001_00_00_0010;
  localparam logic [15:0] E_BEQ_Z0  = 16'b0000_1000_00_01_0110;
  localparam logic [15:0] E_BEQ_Z1  = 16'b1000_1000_00_01_0110;
  localparam logic [15:0] E_ADDIEX  = 16'b0000_1000_10_00_0010;
  localparam logic [15:0] E_ADDIWB  = 16'b0001_0000_00_00_0010;
  localparam logic [15:0] E_JEX     = 16'b1000_0000_00_10_0010;

  function automatic logic [15:0] e_rex(input logic [3:0] alu);
    return {12'b0000_1000_00_00, alu};
  endfunction

  task automatic chk(input string tag, input logic [15:0] exp);
    #1;
    checks++;
    assert (sig === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, sig, exp);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] exp);
    @(posedge clk);
    chk(tag, exp);
  endtask

  // Starts in FETCH; runs DECODE, n execute states, then expects FETCH again.
  task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input int n,
                     input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
    bus.op = o; bus.funct = f; bus.zero = z;
    chk({tag, ":fetch"}, E_FETCH);
    step({tag, ":decode"}, E_DECODE);
    if (n > 0) step({tag, ":s1"}, e1);
    if (n > 1) step({tag, ":s2"}, e2);
    if (n > 2) step({tag, ":s3"}, e3);
    step({tag, ":refetch"}, E_FETCH);
  endtask

  initial begin
    reset = 1'b0;
    bus.op = 6'b000000; bus.funct = 6'b100000; bus.zero = 1'b0;
    @(posedge clk);
    chk("reset_hold", E_RST);
    reset = 1'b1;

    for (int zz = 0; zz < 2; zz++) begin
      logic z;
      z = zz[0];
      run("add",  6'b000000, 6'b100000, z, 2, e_rex(4'b0010), E_RWB, 16'h0);
      run("sub",  6'b000000, 6'b100010, z, 2, e_rex(4'b0110), E_RWB, 16'h0);
      run("and",  6'b000000, 6'b100100, z, 2, e_rex(4'b0000), E_RWB, 16'h0);
      run("or",   6'b000000, 6'b100101, z, 2, e_rex(4'b0001), E_RWB, 16'h0);
      run("slt",  6'b000000, 6'b101010, z, 2, e_rex(4'b0111), E_RWB, 16'h0);
      run("rbad", 6'b000000, 6'b111111, z, 2, e_rex(4'b0010), E_RWB, 16'h0);
      run("lw",   6'b100011, 6'b000000, z, 3, E_MEMADR, E_MEMRD, E_MEMWB);
      run("sw",   6'b101011, 6'b000000, z, 2, E_MEMADR, E_MEMWR, 16'h0);
      run("beq",  6'b000100, 6'b000000, z, 1, z ? E_BEQ_Z1 : E_BEQ_Z0, 16'h0, 16'h0);
      run("addi", 6'b001000, 6'b000000, z, 2, E_ADDIEX, E_ADDIWB, 16'h0);
      run("j",    6'b000010, 6'b000000, z, 1, E_JEX, 16'h0, 16'h0);
      run("undef", 6'b111111, 6'b000000, z, 0, 16'h0, 16'h0, 16'h0);
`ifdef CTRL_BNE_EN
      run("bne",  6'b000101, 6'b000000, z, 1, z ? E_BEQ_Z0 : E_BEQ_Z1, 16'h0, 16'h0);
`else
      run("bne_undef", 6'b000101, 6'b000000, z, 0, 16'h0, 16'h0, 16'h0);
`endif
    end

    // reset in the middle of lw: abandons the instruction
    bus.op = 6'b100011; bus.funct = 6'b000000; bus.zero = 1'b0;
    chk("mid:fetch", E_FETCH);
    step("mid:decode", E_DECODE);
    step("mid:memadr", E_MEMADR);
    step("mid:memrd", E_MEMRD);
    reset = 1'b0;
    chk("mid:rst_comb", E_RST);
    step("mid:rst_edge", E_RST);
    step("mid:rst_edge2", E_RST);
    reset = 1'b1;
    run("post_rst_sw", 6'b101011, 6'b000000, 1'b1, 2, E_MEMADR, E_MEMWR, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
